// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-way intersection controller:
// the phase enumeration, the one-hot lamp codes and a duration clamp helper.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_1,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_2,
    WALK,
    FLASH
  } phase_t;

  // Lamp codes are {red, yellow, green}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  function automatic int at_least_one(input int t);
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running prescaler: counts 0..CLK_FREQ-1 and flags the terminal count
// as a one-cycle sec_tick. Only reset clears it.
module sec_tick_gen #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic sec_tick
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_FREQ - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || count_reg == TC) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign sec_tick = (count_reg == TC);

endmodule

// File: rtl/traffic_ctrl_2way.sv
// Two-direction traffic controller with pedestrian walk phase and green
// shortening. Define TRAFFIC_FLASH_EN to build the maintenance flash mode.
module traffic_ctrl_2way
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int CNT_W     = 6,
  parameter int T_GREEN   = 10,
  parameter int T_YELLOW  = 5,
  parameter int T_ALLRED  = 1,
  parameter int T_WALK    = 8,
  parameter int T_PED_CUT = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             ped_req,
  input  logic             flash_req,
  output logic             ped_ack,
  output logic             ped_walk,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] remain
);

  localparam logic [CNT_W-1:0] D_GREEN  = CNT_W'(at_least_one(T_GREEN));
  localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(at_least_one(T_YELLOW));
  localparam logic [CNT_W-1:0] D_ALLRED = CNT_W'(at_least_one(T_ALLRED));
  localparam logic [CNT_W-1:0] D_WALK   = CNT_W'(at_least_one(T_WALK));
  localparam logic [CNT_W-1:0] D_CUT    = CNT_W'(at_least_one(T_PED_CUT));

  function automatic phase_t next_phase(input phase_t p, input logic pend);
    case (p)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALLRED_1;
      ALLRED_1:  return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALLRED_2;
      ALLRED_2:  return pend ? WALK : NS_GREEN;
      default:   return NS_GREEN;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dur_of(input phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   return D_GREEN;
      NS_YELLOW, EW_YELLOW: return D_YELLOW;
      WALK:                 return D_WALK;
      default:              return D_ALLRED;
    endcase
  endfunction

  // Packed as {ns, ew}
  function automatic logic [5:0] heads_of(input phase_t p);
    case (p)
      NS_GREEN:  return {L_GRN, L_RED};
      NS_YELLOW: return {L_YEL, L_RED};
      EW_GREEN:  return {L_RED, L_GRN};
      EW_YELLOW: return {L_RED, L_YEL};
      default:   return {L_RED, L_RED};
    endcase
  endfunction

  logic   sec_tick;
  phase_t phase_reg;
  phase_t nxt;
  logic   ped_pend_reg;
  logic   expire;
  logic   is_green;
  logic   walk_entry;

  sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .sec_tick (sec_tick)
  );

  assign expire   = sec_tick && (remain == CNT_W'(1));
  assign nxt      = next_phase(phase_reg, ped_pend_reg);
  assign is_green = (phase_reg == NS_GREEN) || (phase_reg == EW_GREEN);

`ifdef TRAFFIC_FLASH_EN
  logic flash_on_reg;
  // A flash request pre-empts the phase advance, so no walk entry that cycle
  assign walk_entry = !flash_req && expire && (nxt == WALK);
`else
  logic unused_flash;
  assign unused_flash = flash_req;
  assign walk_entry   = expire && (nxt == WALK);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase_reg    <= NS_GREEN;
      remain       <= D_GREEN;
      ns_light     <= L_GRN;
      ew_light     <= L_RED;
      ped_walk     <= 1'b0;
      ped_ack      <= 1'b0;
      ped_pend_reg <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
      flash_on_reg <= 1'b0;
`endif
    end else begin
      ped_ack <= 1'b0;
      // A request on the walk-entry cycle re-arms the latch and is acknowledged
      if (ped_req) begin
        ped_pend_reg <= 1'b1;
        if (!ped_pend_reg || walk_entry) ped_ack <= 1'b1;
      end else if (walk_entry) begin
        ped_pend_reg <= 1'b0;
      end

`ifdef TRAFFIC_FLASH_EN
      if (flash_req) begin
        if (phase_reg != FLASH) begin
          phase_reg    <= FLASH;
          flash_on_reg <= 1'b1;
          ns_light     <= L_YEL;
          ew_light     <= L_YEL;
          remain       <= '0;
          ped_walk     <= 1'b0;
        end else if (sec_tick) begin
          flash_on_reg <= !flash_on_reg;
          ns_light     <= flash_on_reg ? L_OFF : L_YEL;
          ew_light     <= flash_on_reg ? L_OFF : L_YEL;
        end
      end else if (phase_reg == FLASH) begin
        phase_reg <= ALLRED_2;
        remain    <= D_ALLRED;
        ns_light  <= L_RED;
        ew_light  <= L_RED;
      end else
`endif
      if (expire) begin
        phase_reg              <= nxt;
        remain                 <= dur_of(nxt);
        {ns_light, ew_light}   <= heads_of(nxt);
        ped_walk               <= (nxt == WALK);
      end else if (sec_tick) begin
        if (is_green && ped_pend_reg && remain > D_CUT) remain <= D_CUT;
        else remain <= remain - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Directed bench for traffic_ctrl_2way with CLK_FREQ=4 (one second = 4 cycles).
// Cycle 0 is the first cycle after reset release; the flash checks follow TRAFFIC_FLASH_EN.
module tb_traffic_ctrl_2way;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       flash_req = 1'b0;
  logic       ped_ack;
  logic       ped_walk;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [5:0] remain;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acks = 0;
  logic [2:0] e_ns;
  logic [2:0] e_ew;
  logic [5:0] e_rem;

  always #5 sys_clk = ~sys_clk;

  traffic_ctrl_2way #(
    .CLK_FREQ (4),
    .CNT_W    (6),
    .T_GREEN  (6),
    .T_YELLOW (2),
    .T_ALLRED (1),
    .T_WALK   (3),
    .T_PED_CUT(2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ped_req  (ped_req),
    .flash_req(flash_req),
    .ped_ack  (ped_ack),
    .ped_walk (ped_walk),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .remain   (remain)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                           input logic [5:0] rem, input logic walk);
    chk({tag, " ns"}, 32'(ns_light), 32'(ns));
    chk({tag, " ew"}, 32'(ew_light), 32'(ew));
    chk({tag, " remain"}, 32'(remain), 32'(rem));
    chk({tag, " walk"}, 32'(ped_walk), 32'(walk));
  endtask

  // Undisturbed 72-cycle sequence, derived from the phase durations
  task automatic exp_normal(input int c);
    int t;
    t = c % 72;
    if (t < 24) begin
      e_ns = 3'b001; e_ew = 3'b100; e_rem = 6'(6 - t / 4);
    end else if (t < 32) begin
      e_ns = 3'b010; e_ew = 3'b100; e_rem = 6'(2 - (t - 24) / 4);
    end else if (t < 36) begin
      e_ns = 3'b100; e_ew = 3'b100; e_rem = 6'd1;
    end else if (t < 60) begin
      e_ns = 3'b100; e_ew = 3'b001; e_rem = 6'(6 - (t - 36) / 4);
    end else if (t < 68) begin
      e_ns = 3'b100; e_ew = 3'b010; e_rem = 6'(2 - (t - 60) / 4);
    end else begin
      e_ns = 3'b100; e_ew = 3'b100; e_rem = 6'd1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and the undisturbed cycle
    do_reset();
    chk("reset ack", 32'(ped_ack), 0);
    for (int c = 0; c <= 73; c++) begin
      step_to(c);
      exp_normal(c);
      chk_state("normal", e_ns, e_ew, e_rem, 1'b0);
      chk("normal ack", 32'(ped_ack), 0);
    end
    $display("normal sequence: checked cycles 0..73");

    // Single ped pulse at cycle 2
    do_reset();
    step_to(2);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("pulse ack", 32'(ped_ack), 1);
    chk_state("pulse c3", 3'b001, 3'b100, 6'd6, 1'b0);
    step_to(4);
    chk("pulse ack drop", 32'(ped_ack), 0);
    chk_state("pulse cut ns", 3'b001, 3'b100, 6'd2, 1'b0);
    step_to(11);
    chk_state("pulse ns last", 3'b001, 3'b100, 6'd1, 1'b0);
    step_to(12);
    chk_state("pulse ns yel", 3'b010, 3'b100, 6'd2, 1'b0);
    step_to(24);
    chk_state("pulse ew grn", 3'b100, 3'b001, 6'd6, 1'b0);
    step_to(28);
    chk_state("pulse cut ew", 3'b100, 3'b001, 6'd2, 1'b0);
    step_to(36);
    chk_state("pulse ew yel", 3'b100, 3'b010, 6'd2, 1'b0);
    step_to(47);
    chk_state("pulse allred2", 3'b100, 3'b100, 6'd1, 1'b0);
    step_to(48);
    chk_state("pulse walk", 3'b100, 3'b100, 6'd3, 1'b1);
    chk("pulse walk ack", 32'(ped_ack), 0);
    step_to(59);
    chk_state("pulse walk end", 3'b100, 3'b100, 6'd1, 1'b1);
    step_to(60);
    chk_state("pulse ns back", 3'b001, 3'b100, 6'd6, 1'b0);
    step_to(64);
    chk_state("pulse no cut", 3'b001, 3'b100, 6'd5, 1'b0);
    $display("ped pulse: walk served, pending cleared");

    // ped_req held 40 cycles: one ack only
    do_reset();
    ped_req = 1'b1;
    acks = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 40) ped_req = 1'b0;
      if (ped_ack) acks++;
    end
    chk("held40 acks", 32'(acks), 1);
    chk_state("held40 ns back", 3'b001, 3'b100, 6'd6, 1'b0);
    step_to(64);
    chk_state("held40 no cut", 3'b001, 3'b100, 6'd5, 1'b0);
    $display("ped held 40 cycles: acks=%0d", acks);

    // ped_req held across WALK entry: second ack and request stays pending
    do_reset();
    ped_req = 1'b1;
    acks = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 50) ped_req = 1'b0;
      if (ped_ack) acks++;
      if (c == 48) chk("held50 walk ack", 32'(ped_ack), 1);
    end
    chk("held50 acks", 32'(acks), 2);
    step_to(64);
    chk_state("held50 recut", 3'b001, 3'b100, 6'd2, 1'b0);
    $display("ped held across walk entry: acks=%0d", acks);

    // Reset in EW_YELLOW clears phase, prescaler and pending request
    do_reset();
    step_to(61);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("pre-reset ack", 32'(ped_ack), 1);
    sys_rst = 1'b1;
    step();
    chk_state("midrst", 3'b001, 3'b100, 6'd6, 1'b0);
    chk("midrst ack", 32'(ped_ack), 0);
    sys_rst = 1'b0;
    cyc = 0;
    step_to(3);
    chk_state("midrst c3", 3'b001, 3'b100, 6'd6, 1'b0);
    step_to(4);
    chk_state("midrst c4", 3'b001, 3'b100, 6'd5, 1'b0);
    step_to(23);
    chk_state("midrst c23", 3'b001, 3'b100, 6'd1, 1'b0);
    step_to(24);
    chk_state("midrst c24", 3'b010, 3'b100, 6'd2, 1'b0);
    $display("reset mid EW_YELLOW: restart checked");

    // flash_req during EW_GREEN, cycles 40..50
    do_reset();
    step_to(40);
    flash_req = 1'b1;
`ifdef TRAFFIC_FLASH_EN
    step_to(41);
    chk_state("flash on", 3'b010, 3'b010, 6'd0, 1'b0);
    step_to(43);
    chk_state("flash on hold", 3'b010, 3'b010, 6'd0, 1'b0);
    step_to(44);
    chk_state("flash off", 3'b000, 3'b000, 6'd0, 1'b0);
    step_to(47);
    chk_state("flash off hold", 3'b000, 3'b000, 6'd0, 1'b0);
    step_to(48);
    chk_state("flash on again", 3'b010, 3'b010, 6'd0, 1'b0);
    step_to(51);
    flash_req = 1'b0;
    step_to(52);
    chk_state("flash exit", 3'b100, 3'b100, 6'd1, 1'b0);
    step_to(55);
    chk_state("flash allred", 3'b100, 3'b100, 6'd1, 1'b0);
    step_to(56);
    chk_state("flash resume", 3'b001, 3'b100, 6'd6, 1'b0);
    $display("flash mode: entry, blink and exit checked");
`else
    for (int c = 41; c <= 72; c++) begin
      step_to(c);
      if (c == 51) flash_req = 1'b0;
      exp_normal(c);
      chk_state("noflash", e_ns, e_ew, e_rem, 1'b0);
    end
    $display("flash_req ignored: sequence checked cycles 41..72");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
